// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO. The baud divisor and the frame format
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) are set at runtime.
// Queued bytes are sent back-to-back, with no idle time between frames.
module uart_tx_fifo #(
    parameter int DIV_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic [1:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    state_t           state;
    state_t           state_d;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       head;
    logic [7:0]       mask;
    logic             par_en_q;
    logic             par_bit_q;
    logic             stop2_q;
    logic             txd_q;
    logic             txd_d;
    logic             pop;
    logic             wr_en;
    logic             bit_end;
    logic             last_stop;
    logic             fifo_empty;

    // Parity over the bits that are actually sent; odd parity is the inverse.
    function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == 2'b10);
    endfunction

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign in_ready   = (fifo_level != FULL_LVL);
    assign wr_en      = in_valid && in_ready && !rst;
    assign busy       = (state != S_IDLE) || !fifo_empty;
    assign txd        = txd_q;
    assign bit_end    = (cnt == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign mask       = 8'hFF >> (2'd3 - cfg_data_bits);

    // FIFO storage. Only the pointers carry reset; the contents do not.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // Control state: FSM state, registered TXD and the FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            txd_q  <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_d;
            txd_q <= txd_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Next-state logic. A pop starts a start bit, whether from IDLE or directly
    // at the end of the last stop bit.
    always_comb begin
        state_d   = state;
        txd_d     = txd_q;
        pop       = 1'b0;
        last_stop = 1'b0;
        case (state)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx != 3'd0) begin
                        txd_d = shreg[1];
                    end else if (par_en_q) begin
                        state_d = S_PARITY;
                        txd_d   = par_bit_q;
                    end else begin
                        state_d = S_STOP1;
                        txd_d   = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP1;
                    txd_d   = 1'b1;
                end
            end
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        last_stop = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (bit_end) begin
                    last_stop = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (last_stop) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = S_START;
                txd_d   = 1'b0;
            end else begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        end
    end

    // Per-frame datapath: latch the configuration at the pop, count bit
    // periods and shift the data out LSB first.
    always_ff @(posedge clk) begin
        if (pop) begin
            cnt       <= baud_div;
            div_q     <= baud_div;
            shreg     <= head & mask;
            bit_idx   <= {1'b1, cfg_data_bits};
            par_en_q  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_q <= frame_parity(head & mask, cfg_parity);
            stop2_q   <= cfg_stop2;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                cnt <= div_q;
                if (state == S_DATA && bit_idx != 3'd0) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx - 3'd1;
                end
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DEPTH=4), with immediate-assertion checks.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_assert = 0;
    int n_fail   = 0;

    logic samp [0:202];
    logic bsy  [0:202];

    uart_tx_fifo #(.DIV_W(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .txd(txd), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame as a bit vector, sent from bit 0 upward.
    function automatic logic [15:0] make_frame(input logic [7:0] d, input int nb,
                                               input int par, input bit s2, output int len);
        logic [15:0] v;
        logic        p;
        int          i;
        v = '0;
        p = 1'b0;
        i = 1;
        for (int k = 0; k < nb; k++) begin
            v[i] = d[k];
            p    = p ^ d[k];
            i++;
        end
        if (par == 1) begin v[i] = p;  i++; end
        if (par == 2) begin v[i] = ~p; i++; end
        v[i] = 1'b1; i++;
        if (s2) begin v[i] = 1'b1; i++; end
        len = i;
        return v;
    endfunction

    // Called right after the edge that starts a start bit.
    task automatic check_frame(input string tag, input logic [15:0] vec, input int len,
                               input int div, input bit end_idle);
        for (int b = 0; b < len; b++) begin
            int good = 0;
            for (int c = 0; c <= div; c++) begin
                if (txd === vec[b]) good++;
                tick();
            end
            chk($sformatf("%s bit%0d clocks at level %0d", tag, b, vec[b]), good, div + 1);
        end
        if (end_idle) begin
            chk({tag, " busy after frame"}, busy, 0);
            chk({tag, " txd after frame"}, txd, 1);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        int w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 5000) begin tick(); w++; end
        chk("write ready wait", int'(w < 5000), 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] fv;
        int          fl;
        int          waited;
        int          nxt;
        int          bad;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        baud_div = 16'd3; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("reset txd", txd, 1);
        chk("reset busy", busy, 0);
        chk("reset level", fifo_level, 0);
        chk("reset in_ready", in_ready, 1);

        // 8N1 0x55, 4 clocks per bit
        write_byte(8'h55);
        chk("8N1 level after accept", fifo_level, 1);
        chk("8N1 busy after accept", busy, 1);
        chk("8N1 txd idle after accept", txd, 1);
        tick();
        chk("8N1 level after pop", fifo_level, 0);
        check_frame("8N1", 16'h02AA, 10, 3, 1'b1);

        // 7E1 0xC1, 2 clocks per bit
        baud_div = 16'd1; cfg_data_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
        write_byte(8'hC1);
        tick();
        check_frame("7E1", 16'h0282, 10, 1, 1'b1);

        // 5O2 0x1F
        cfg_data_bits = 2'b00; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        write_byte(8'h1F);
        tick();
        check_frame("5O2", 16'h01BE, 9, 1, 1'b1);

        // FIFO full with 100 clocks per bit
        baud_div = 16'd99; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
        end
        chk("full level", fifo_level, 4);
        chk("full in_ready", in_ready, 0);
        in_data = 8'hA5;
        waited = 0;
        while (!in_ready && waited < 2000) begin tick(); waited++; end
        chk("full wait for in_ready", waited, 997);
        chk("full level after pop", fifo_level, 3);
        tick();
        in_valid = 1'b0;
        chk("full level after byte6", fifo_level, 4);
        chk("full in_ready after byte6", in_ready, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("flush level", fifo_level, 0);

        // Back-to-back stream of 20 bytes, 1 clock per bit
        baud_div = 16'd0;
        nxt = 0;
        for (int s = 0; s <= 202; s++) begin
            if (nxt < 20) begin
                in_valid = 1'b1;
                in_data  = 8'(nxt);
            end else begin
                in_valid = 1'b0;
            end
            samp[s] = txd;
            bsy[s]  = busy;
            if (in_valid && in_ready) nxt++;
            tick();
        end
        in_valid = 1'b0;
        chk("stream all accepted", nxt, 20);
        for (int f = 0; f < 20; f++) begin
            logic [9:0] got;
            fv = make_frame(8'(f), 8, 0, 1'b0, fl);
            for (int b = 0; b < 10; b++) got[b] = samp[2 + 10*f + b];
            chk($sformatf("stream frame %0d", f), int'(got), int'(fv[9:0]));
        end
        chk("stream busy at last stop", bsy[201], 1);
        chk("stream busy after 200", bsy[202], 0);

        // Configuration change during a frame
        baud_div = 16'd3; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        write_byte(8'hA5);
        write_byte(8'h3C);
        baud_div = 16'd7; cfg_parity = 2'b01;
        fv = make_frame(8'hA5, 8, 0, 1'b0, fl);
        check_frame("cfg 8N1 frame", fv, fl, 3, 1'b0);
        fv = make_frame(8'h3C, 8, 1, 1'b0, fl);
        check_frame("cfg 8E1 frame", fv, fl, 7, 1'b1);

        // Reset during data bit 3
        baud_div = 16'd3; cfg_parity = 2'b00;
        in_valid = 1'b1;
        in_data = 8'h08; tick();
        in_data = 8'h09; tick();
        in_data = 8'h0A; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("rst mid data bit3 txd", txd, 1);
        chk("rst mid level", fifo_level, 2);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst mid txd", txd, 1);
        chk("rst mid level after", fifo_level, 0);
        chk("rst mid in_ready", in_ready, 1);
        chk("rst mid busy", busy, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
            tick();
        end
        chk("rst no further frames", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
